// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Parametrised single-clock FIFO for producer/consumer stages sharing one
//   clock. It has configurable width and depth, an occupancy count,
//   programmable almost-full/almost-empty thresholds, and one-cycle
//   overflow/underflow pulses. It can run as a registered-read FIFO or in
//   first-word-fall-through mode.
//
// Ports
//   clk           rising-edge clock for all logic
//   reset         synchronous active-high reset
//   w_en          write request
//   data_in       write data [WIDTH]
//   r_en          read request (in fall-through mode this pops the head)
//   data_out      read data [WIDTH]
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy 0..DEPTH [AW+1]
//   overflow      one-cycle pulse: a write was rejected in the previous cycle
//   underflow     one-cycle pulse: a read was rejected in the previous cycle

module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      w_ptr;
    logic [AW:0]      r_ptr;
    logic [AW-1:0]    w_addr;
    logic [AW-1:0]    r_addr;
    logic             wr_ok;
    logic             rd_ok;

    assign w_addr = w_ptr[AW-1:0];
    assign r_addr = r_ptr[AW-1:0];

    // The extra wrap bit lets the pointer difference cover 0..DEPTH.
    assign count        = w_ptr - r_ptr;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A read frees a slot in the same cycle, so a full FIFO still accepts
    // a write when a read is also accepted.
    assign rd_ok = r_en & ~empty;
    assign wr_ok = w_en & (~full | rd_ok);

    // The storage array has no reset. Stale words are never visible
    // because the pointers are reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[w_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end
            overflow  <= w_en & ~wr_ok;
            underflow <= r_en & ~rd_ok;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // The head word is presented directly. The output is forced to
            // zero while empty so that unwritten memory never shows on it.
            assign data_out = empty ? '0 : mem[r_addr];
        end else begin : g_reg
            logic [WIDTH-1:0] data_q;

            // The output holds its last value when no read is accepted.
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q <= '0;
                end else if (rd_ok) begin
                    data_q <= mem[r_addr];
                end
            end

            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance
    logic             reset, w_en, r_en;
    logic [WIDTH-1:0] data_in, data_out;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]      count;

    // Fall-through instance
    logic             reset1, w_en1, r_en1;
    logic [WIDTH-1:0] data_in1, data_out1;
    logic             full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
    logic [AW:0]      count1;

    fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) u_reg (
        .clk(clk), .reset(reset), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset(reset1), .w_en(w_en1), .data_in(data_in1), .r_en(r_en1),
        .data_out(data_out1), .full(full1), .empty(empty1),
        .almost_full(almost_full1), .almost_empty(almost_empty1), .count(count1),
        .overflow(overflow1), .underflow(underflow1)
    );

    typedef struct {
        bit       w;
        bit       r;
        bit [7:0] d;
        int       cnt;
        bit       ovf;
        bit       udf;
    } vec_t;

    vec_t     vt[$];
    bit [7:0] sb[$];
    bit [7:0] last_data;
    int       n_vec = 0;
    int       n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int cnt, input bit ovf, input bit udf);
        chk({tag, " count"}, int'(count), cnt);
        chk({tag, " full"}, int'(full), int'(cnt == DEPTH));
        chk({tag, " empty"}, int'(empty), int'(cnt == 0));
        chk({tag, " almost_full"}, int'(almost_full), int'(cnt >= DEPTH - 2));
        chk({tag, " almost_empty"}, int'(almost_empty), int'(cnt <= 2));
        chk({tag, " overflow"}, int'(overflow), int'(ovf));
        chk({tag, " underflow"}, int'(underflow), int'(udf));
    endtask

    task automatic push_vec(input bit w, input bit r, input bit [7:0] d,
                            input int cnt, input bit ovf, input bit udf);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
        vt.push_back(v);
    endtask

    initial begin
        int c;

        // Build the vector table.
        c = 0;
        for (int i = 0; i < DEPTH; i++) begin
            c++;
            push_vec(1'b1, 1'b0, 8'(i + 1), c, 1'b0, 1'b0);
        end
        push_vec(1'b1, 1'b0, 8'hEE, DEPTH, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            c--;
            push_vec(1'b0, 1'b1, 8'h00, c, 1'b0, 1'b0);
        end
        push_vec(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1);
        push_vec(1'b1, 1'b1, 8'hAA, 1, 1'b0, 1'b1);
        push_vec(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            push_vec(1'b1, 1'b0, 8'(8'h20 + i), i + 1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            push_vec(1'b1, 1'b1, 8'(8'h40 + i), DEPTH, 1'b0, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            push_vec(1'b0, 1'b1, 8'h00, DEPTH - 1 - i, 1'b0, 1'b0);
        end

        reset = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
        reset1 = 1'b1; w_en1 = 1'b0; r_en1 = 1'b0; data_in1 = '0;
        tick();
        tick();
        reset = 1'b0;
        reset1 = 1'b0;

        chk_flags("reset", 0, 1'b0, 1'b0);
        chk("reset data_out", int'(data_out), 0);
        last_data = 8'h00;

        // Table-driven part, with data checked against the scoreboard.
        for (int k = 0; k < vt.size(); k++) begin
            w_en = vt[k].w; r_en = vt[k].r; data_in = vt[k].d;
            tick();
            w_en = 1'b0; r_en = 1'b0;
            chk_flags($sformatf("vec%0d", k), vt[k].cnt, vt[k].ovf, vt[k].udf);
            if (vt[k].r && !vt[k].udf) begin
                if (sb.size() == 0) begin
                    chk($sformatf("vec%0d scoreboard empty", k), 1, 0);
                end else begin
                    last_data = sb.pop_front();
                end
            end
            if (vt[k].w && !vt[k].ovf) begin
                sb.push_back(vt[k].d);
            end
            chk($sformatf("vec%0d data_out", k), int'(data_out), int'(last_data));
        end
        chk("scoreboard drained", sb.size(), 0);

        // Reset with 9 entries stored and both requests active.
        for (int i = 0; i < 9; i++) begin
            w_en = 1'b1; data_in = 8'(8'h60 + i);
            tick();
        end
        w_en = 1'b0;
        chk("pre-reset count", int'(count), 9);
        w_en = 1'b1; r_en = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; w_en = 1'b0; r_en = 1'b0;
        chk_flags("midreset", 0, 1'b0, 1'b0);
        chk("midreset data_out", int'(data_out), 0);
        tick();
        chk_flags("postreset idle", 0, 1'b0, 1'b0);
        // Stored data must be gone: a read now underflows and leaves the output at 0.
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        chk_flags("postreset read", 0, 1'b0, 1'b1);
        chk("postreset data_out", int'(data_out), 0);
        tick();
        chk("underflow single pulse", int'(underflow), 0);

        // Fall-through mode.
        chk("fwft empty data_out", int'(data_out1), 0);
        chk("fwft empty flag", int'(empty1), 1);
        w_en1 = 1'b1; data_in1 = 8'h5A;
        tick();
        w_en1 = 1'b0;
        chk("fwft head 5A", int'(data_out1), 8'h5A);
        chk("fwft not empty", int'(empty1), 0);
        r_en1 = 1'b1;
        tick();
        r_en1 = 1'b0;
        chk("fwft popped data_out", int'(data_out1), 0);
        chk("fwft popped empty", int'(empty1), 1);
        w_en1 = 1'b1; data_in1 = 8'h11;
        tick();
        data_in1 = 8'h22;
        tick();
        w_en1 = 1'b0;
        chk("fwft head 11", int'(data_out1), 8'h11);
        chk("fwft count 2", int'(count1), 2);
        r_en1 = 1'b1;
        tick();
        chk("fwft head 22", int'(data_out1), 8'h22);
        tick();
        chk("fwft drained", int'(empty1), 1);
        chk("fwft no underflow", int'(underflow1), 0);
        tick();
        r_en1 = 1'b0;
        chk("fwft underflow", int'(underflow1), 1);
        chk("fwft no overflow", int'(overflow1), 0);
        chk("fwft flags full", int'(full1), 0);
        chk("fwft almost_empty", int'(almost_empty1), 1);
        chk("fwft almost_full", int'(almost_full1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
